// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption sequencer.
// Holds the cipher state and round-key registers and steps one shared round
// datapath and one key-expansion function through the initial AddRoundKey
// and rounds 1..NR, with valid/ready handshakes on both block streams.
module aes_round_ctrl #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] key,
  input  logic [127:0] plaintext,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         busy,
  output logic [3:0]   round,
  output logic [127:0] rnd_in,
  output logic [127:0] rnd_key,
  output logic         rnd_last,
  input  logic [127:0] rnd_out,
  output logic [127:0] ks_in,
  output logic [7:0]   ks_rcon,
  input  logic [127:0] ks_out
);

  localparam logic [3:0] LastRound = 4'(NR);

  typedef enum logic [1:0] {StIdle, StRound, StDone} state_e;

  state_e       r_fsm;
  state_e       w_fsm_next;
  logic [127:0] r_state;
  logic [127:0] r_rkey;
  logic [3:0]   r_round;
  logic         w_accept;
  logic [7:0]   w_rcon;

  assign w_accept = in_valid && in_ready;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm <= StIdle;
    end else begin
      r_fsm <= w_fsm_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_fsm_next = r_fsm;
    case (r_fsm)
      StIdle:  if (w_accept) w_fsm_next = StRound;
      StRound: if (r_round == LastRound) w_fsm_next = StDone;
      StDone:  if (out_ready) w_fsm_next = StIdle;
      default: w_fsm_next = StIdle;
    endcase
  end

  // Cipher state, round key and round counter updates
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= '0;
      r_rkey  <= '0;
      r_round <= '0;
    end else begin
      case (r_fsm)
        StIdle: begin
          // Key and plaintext are sampled only here; later bus changes are ignored.
          if (w_accept) begin
            r_state <= plaintext ^ key;
            r_rkey  <= key;
            r_round <= 4'd1;
          end
        end
        StRound: begin
          r_state <= rnd_out;
          r_rkey  <= ks_out;
          if (r_round != LastRound) r_round <= r_round + 4'd1;
        end
        StDone: begin
          if (out_ready) r_round <= '0;
        end
        default: ;
      endcase
    end
  end

  // Round constant lookup, indexed by the current round
  always_comb begin
    case (r_round)
      4'd1:    w_rcon = 8'h01;
      4'd2:    w_rcon = 8'h02;
      4'd3:    w_rcon = 8'h04;
      4'd4:    w_rcon = 8'h08;
      4'd5:    w_rcon = 8'h10;
      4'd6:    w_rcon = 8'h20;
      4'd7:    w_rcon = 8'h40;
      4'd8:    w_rcon = 8'h80;
      4'd9:    w_rcon = 8'h1b;
      4'd10:   w_rcon = 8'h36;
      default: w_rcon = 8'h00;
    endcase
  end

  // FSM output decode; handshake outputs are held low while reset is asserted
  always_comb begin
    in_ready  = (r_fsm == StIdle) && !rst;
    out_valid = (r_fsm == StDone) && !rst;
    busy      = (r_fsm != StIdle);
    rnd_last  = (r_fsm == StRound) && (r_round == LastRound);
    ks_rcon   = (r_fsm == StRound) ? w_rcon : 8'h00;
  end

  assign ciphertext = r_state;
  assign rnd_in     = r_state;
  assign ks_in      = r_rkey;
  assign rnd_key    = ks_out;
  assign round      = r_round;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl. A behavioural AES round and key
// schedule (S-box derived from the GF(2^8) inverse) drive the rnd_*/ks_* ports
// and provide the reference encryption.
module tb_aes_round_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] key;
  logic [127:0] plaintext;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;
  logic         busy;
  logic [3:0]   round;
  logic [127:0] rnd_in;
  logic [127:0] rnd_key;
  logic         rnd_last;
  logic [127:0] rnd_out;
  logic [127:0] ks_in;
  logic [7:0]   ks_rcon;
  logic [127:0] ks_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  aes_round_ctrl #(.NR(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .key        (key),
    .plaintext  (plaintext),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ciphertext (ciphertext),
    .busy       (busy),
    .round      (round),
    .rnd_in     (rnd_in),
    .rnd_key    (rnd_key),
    .rnd_last   (rnd_last),
    .rnd_out    (rnd_out),
    .ks_in      (ks_in),
    .ks_rcon    (ks_rcon),
    .ks_out     (ks_out)
  );

  // ---------------- reference AES model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p  = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv  = 8'h01;
    logic [7:0] base = x;
    logic [7:0] e    = 8'hfe;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) inv = gmul(inv, base);
      base = gmul(base, base);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [7:0]   a[16];
    logic [7:0]   t[16];
    logic [7:0]   m[16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = sbox(s[127-8*i -: 8]);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) t[r+4*c] = a[r+4*((c+r)%4)];
    for (int c = 0; c < 4; c++) begin
      if (last) begin
        for (int r = 0; r < 4; r++) m[r+4*c] = t[r+4*c];
      end else begin
        m[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
        m[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
        m[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
        m[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = m[i];
    return o ^ k;
  endfunction

  function automatic logic [127:0] key_exp(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w3  = k[31:0];
    logic [31:0] rot = {w3[23:0], w3[31:24]};
    logic [31:0] tmp;
    logic [31:0] n0, n1, n2, n3;
    tmp = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^ {rc, 24'h0};
    n0  = k[127:96] ^ tmp;
    n1  = k[95:64] ^ n0;
    n2  = k[63:32] ^ n1;
    n3  = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] ref_encrypt(input logic [127:0] k, input logic [127:0] p);
    logic [127:0] s  = p ^ k;
    logic [127:0] rk = k;
    logic [7:0]   rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      rk = key_exp(rk, rc);
      s  = aes_round(s, rk, r == 10);
      rc = xt(rc);
    end
    return s;
  endfunction

  assign rnd_out = aes_round(rnd_in, rnd_key, rnd_last);
  assign ks_out  = key_exp(ks_in, ks_rcon);

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Runs one block from IDLE; checks each round step and 11-cycle latency.
  task automatic run_block(input logic [127:0] k, input logic [127:0] p,
                           input logic [127:0] exp, input string tag,
                           input bit churn, input bit hold_out);
    logic [127:0] s  = p ^ k;
    logic [127:0] rk = k;
    logic [7:0]   rc = 8'h01;
    check({tag, " in_ready_pre"}, in_ready, 1);
    key = k; plaintext = p; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int r = 1; r <= 10; r++) begin
      check({tag, " round"}, round, r);
      check({tag, " rnd_last"}, rnd_last, r == 10);
      check({tag, " ks_rcon"}, ks_rcon, rc);
      check({tag, " rnd_in"}, rnd_in, s);
      check({tag, " in_ready_busy"}, {in_ready, busy, out_valid}, 3'b010);
      rk = key_exp(rk, rc);
      s  = aes_round(s, rk, r == 10);
      rc = xt(rc);
      if (churn) begin
        key = rand128(); plaintext = rand128();
        in_valid = 1'($urandom_range(0, 1)); out_ready = 1'($urandom_range(0, 1));
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check({tag, " out_valid_at_11"}, out_valid, 1);
    check({tag, " ciphertext"}, ciphertext, exp);
    check({tag, " round_done"}, round, 10);
    if (!hold_out) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, " idle_after"}, {in_ready, out_valid, busy, round}, {3'b100, 4'd0});
    end
  endtask

  localparam logic [127:0] KeyC1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PtC1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CtC1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KeyB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PtB   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CtB   = 128'h3925841d02dc09fbdc118597196a0b32;

  int           acc[$];
  logic [127:0] res[$];
  bit           acc_now;
  logic [127:0] rk_tmp, pt_tmp;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; key = '0; plaintext = '0;
    tick();
    tick();
    check("rst_handshake_low", {in_ready, out_valid}, 2'b00);
    rst = 1'b0;
    #1;
    check("reset_ctrl", {in_ready, out_valid, busy, rnd_last, round}, {4'b1000, 4'd0});
    check("reset_state", ciphertext, 0);
    check("reset_rkey", ks_in, 0);
    check("reset_rcon", ks_rcon, 0);

    // FIPS-197 C.1 and B vectors; B is then held under back-pressure
    run_block(KeyC1, PtC1, CtC1, "fips_c1", 1'b0, 1'b0);
    run_block(KeyB, PtB, CtB, "fips_b", 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; key = rand128(); plaintext = rand128();
      tick();
      check("bp_hold", {ciphertext, in_ready, out_valid}, {CtB, 2'b01});
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release", {in_ready, out_valid, busy, round}, {3'b100, 4'd0});

    // Back-to-back with in_valid and out_ready held high
    key = KeyC1; plaintext = PtC1; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 40 && res.size() < 2; i++) begin
      acc_now = in_ready && in_valid;
      if (out_valid) res.push_back(ciphertext);
      if (acc_now) acc.push_back(i);
      tick();
      if (acc_now && acc.size() == 1) begin
        key = KeyB; plaintext = PtB;
      end else if (acc_now) begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("b2b_accepts", acc.size(), 2);
    check("b2b_spacing", (acc.size() == 2) ? acc[1] - acc[0] : -1, 12);
    check("b2b_results", res.size(), 2);
    check("b2b_ct0", (res.size() > 0) ? res[0] : 'x, CtC1);
    check("b2b_ct1", (res.size() > 1) ? res[1] : 'x, CtB);
    check("b2b_idle", {in_ready, out_valid, round}, {2'b10, 4'd0});

    // Reset in the middle of round 5
    rk_tmp = rand128(); pt_tmp = rand128();
    key = rk_tmp; plaintext = pt_tmp; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check("midrst_round5", round, 5);
    rst = 1'b1;
    tick();
    check("midrst_handshake_low", {in_ready, out_valid}, 2'b00);
    rst = 1'b0;
    #1;
    check("midrst_after", {in_ready, out_valid, busy, round}, {3'b100, 4'd0});
    rk_tmp = rand128(); pt_tmp = rand128();
    run_block(rk_tmp, pt_tmp, ref_encrypt(rk_tmp, pt_tmp), "midrst_next", 1'b0, 1'b0);

    // Random blocks with key/plaintext churn during ROUND
    for (int i = 0; i < 4; i++) begin
      rk_tmp = rand128(); pt_tmp = rand128();
      run_block(rk_tmp, pt_tmp, ref_encrypt(rk_tmp, pt_tmp), "churn", 1'b1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Iterative AES-128 encryption sequencer that owns the cipher state and round-key registers and drives one shared round datapath and one key-expansion function for ten consecutive cycles per block. It sits between the block-level valid/ready stream and the existing add-key / sbox / shift-rows / mix-columns chain, collapsed into a single reusable round stage. It accepts one block at a time, runs the initial AddRoundKey plus rounds 1–10, and presents the ciphertext with a valid/ready handshake.

## Interface
- NR, 10, number of rounds; fixed for AES-128, and no other value is supported.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  a block is offered on key/plaintext.
- in_ready  output  1  the controller can accept a block.
- key  input  128  cipher key, sampled only on accept.
- plaintext  input  128  input block, sampled only on accept.
- out_valid  output  1  ciphertext is valid.
- out_ready  input  1  the consumer takes the ciphertext.
- ciphertext  output  128  result; equal to the state register.
- busy  output  1  high in ROUND or DONE.
- round  output  4  current round index, 0–10.
- rnd_in  output  128  state fed to the round datapath.
- rnd_key  output  128  round key for the current round (equal to ks_out).
- rnd_last  output  1  high when round==10 (the datapath skips MixColumns).
- rnd_out  input  128  combinational round result.
- ks_in  output  128  previous round key (equal to the rkey register).
- ks_rcon  output  8  Rcon for the current round.
- ks_out  input  128  combinational next round key.

## Operation
- FSM has three states: IDLE, ROUND, DONE. Reset forces IDLE, round=0, out_valid=0, state register=0 and rkey=0.
- **IDLE**
  - in_ready=1.
  - Accept occurs when in_valid && in_ready. On that edge: state <= plaintext ^ key, rkey <= key, round <= 1, FSM goes to ROUND.
- **ROUND** (one cycle per round)
  - Outputs: rnd_in=state, ks_in=rkey, ks_rcon=RCON[round], rnd_key=ks_out, rnd_last=(round==NR).
  - On each edge: state <= rnd_out, rkey <= ks_out.
  - If round==NR, go to DONE and leave round at NR. Otherwise round <= round+1.
- **DONE**
  - out_valid=1 and ciphertext=state.
  - On out_ready, go to IDLE with round <= 0.
  - Without out_ready, ciphertext and out_valid hold indefinitely.
- RCON[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36. Output 00 outside ROUND.
- Byte order is big-endian: bits [127:120] are byte 0, matching the existing datapath stages.
- Outside ROUND, rnd_last=0 and rnd_in/ks_in still mirror the registers; the datapath output is ignored.

## Timing
- Accept at edge E0 is followed by rounds on edges E1..E10. out_valid is high after E10, giving 11 cycles from accept to valid.
- Throughput is one block per 12 cycles with out_ready held high. DONE→IDLE costs one cycle, so there is no accept in the same cycle as the output handshake.
- in_ready=0 throughout ROUND and DONE. in_valid and data changes in those states are ignored, and the sampled key/plaintext are never re-read.
- in_ready and out_valid are pure decodes of the FSM register. Both are forced low while rst=1.
- Reset asserted during ROUND or DONE: the block in flight is discarded with no out_valid pulse, and in_ready=1 on the first cycle after rst deasserts.
- out_ready asserted while not in DONE has no effect.
- round never exceeds 10; there is no wrap-around.

## Test plan
Bench wires a reference round function and key-expansion model to the rnd_* and ks_* ports.
- FIPS-197 C.1: key=000102030405060708090a0b0c0d0e0f, pt=00112233445566778899aabbccddeeff → ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, with out_valid exactly 11 cycles after accept.
- FIPS-197 B: key=2b7e151628aed2a6abf7158809cf4f3c, pt=3243f6a8885a308d313198a2e0370734 → 3925841d02dc09fbdc118597196a0b32. Additionally check round steps 1..10, rnd_last only at round 10, and ks_rcon sequence 01..36.
- Back-pressure: hold out_ready=0 for 20 cycles in DONE → ciphertext stable, in_ready=0, and a new in_valid is not accepted. Release → IDLE next cycle, in_ready=1.
- Back-to-back: in_valid held with two vectors and out_ready=1 → second accept occurs exactly 12 cycles after the first, and both results are correct.
- Mid-block reset: rst at round 5 → next cycle round=0, busy=0, out_valid=0, in_ready=1. A new block then completes correctly.
- Input churn: change key/plaintext every cycle during ROUND → result equals the encryption of the values sampled at accept.
